// File: rtl/mem_stage.sv
// mem_stage: RISC-V memory stage that serialises loads/stores onto a byte-wide data bus.
// Latency: non-memory ops pass through combinationally; a memory op occupies N+2 cycles
// (1 IDLE, N ACCESS, 1 DONE) plus any ram_ready wait cycles.
// Backpressure: stallreq_mem holds the pipeline while in IDLE/ACCESS with a memory op;
// ACCESS waits for ram_ready on every byte.
//
// Ports:
//   clk, rst             pipeline clock, synchronous active-high reset
//   mem_wd/wreg/wdata    EX/MEM destination, write enable, ALU result
//   mem_opcode/func3     instruction fields selecting load/store and access size
//   mem_mem_addr         effective byte address; mem_reg2 store data
//   wb_wd/wreg/wdata     results towards MEM/WB
//   stallreq_mem         freeze request to the stall controller
//   ram_*                byte-wide data bus (addr, wdata, we, re, rdata, ready)
//   mem_err              bus-timeout flag (only live with MEM_BUS_TIMEOUT_EN defined)
//
// Optional feature: define MEM_BUS_TIMEOUT_EN to abort an access after 255 cycles
// without ram_ready; otherwise ACCESS waits forever and mem_err is tied low.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [6:0]  mem_opcode,
  input  logic [2:0]  mem_func3,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq_mem,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic        ram_re,
  input  logic [7:0]  ram_rdata,
  input  logic        ram_ready,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] buf_q, buf_d;

  logic        is_load, is_store, is_mem, size_ok;
  logic [1:0]  last_idx;
  logic [31:0] load_res;
  logic        timed_out;

  assign is_load  = (mem_opcode == 7'b0000011);
  assign is_store = (mem_opcode == 7'b0100011);
  assign is_mem   = (is_load || is_store) && size_ok;

  // Access size: last byte index is N-1.
  always_comb begin
    size_ok  = 1'b1;
    last_idx = 2'd0;
    case (mem_func3)
      3'b000, 3'b100: last_idx = 2'd0;
      3'b001, 3'b101: last_idx = 2'd1;
      3'b010:         last_idx = 2'd3;
      default:        size_ok  = 1'b0;
    endcase
  end

  // Extension of the assembled little-endian buffer.
  always_comb begin
    load_res = buf_q;
    case (mem_func3)
      3'b000:  load_res = {{24{buf_q[7]}}, buf_q[7:0]};
      3'b001:  load_res = {{16{buf_q[15]}}, buf_q[15:0]};
      3'b100:  load_res = {24'd0, buf_q[7:0]};
      3'b101:  load_res = {16'd0, buf_q[15:0]};
      default: load_res = buf_q;
    endcase
  end

`ifdef MEM_BUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;  // set only on the transition into a timed-out DONE
  assign timed_out = err_q;
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
`ifdef MEM_BUS_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif
    wb_wd        = mem_wd;
    wb_wreg      = mem_wreg;
    wb_wdata     = mem_wdata;
    stallreq_mem = 1'b0;
    ram_addr     = 32'd0;
    ram_wdata    = 8'd0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    mem_err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_mem) begin
          stallreq_mem = 1'b1;
          wb_wreg      = 1'b0;
          wb_wdata     = 32'd0;
          state_d      = ACCESS;
          idx_d        = 2'd0;
          buf_d        = 32'd0;
`ifdef MEM_BUS_TIMEOUT_EN
          cnt_d        = 8'd0;
`endif
        end
      end

      ACCESS: begin
        stallreq_mem = 1'b1;
        wb_wreg      = 1'b0;
        wb_wdata     = 32'd0;
        ram_addr     = mem_mem_addr + {30'd0, idx_q};
        ram_re       = is_load;
        ram_we       = is_store;
        ram_wdata    = is_store ? mem_reg2[{idx_q, 3'b000} +: 8] : 8'd0;
        if (ram_ready) begin
          if (is_load) begin
            buf_d[{idx_q, 3'b000} +: 8] = ram_rdata;
          end
          idx_d = idx_q + 2'd1;
`ifdef MEM_BUS_TIMEOUT_EN
          cnt_d = 8'd0;
`endif
          if (idx_q == last_idx) begin
            state_d = DONE;
          end
        end else begin
`ifdef MEM_BUS_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
          // This cycle is the 255th without ready: abandon the access.
          if (cnt_q == 8'd254) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
        if (timed_out) begin
          mem_err  = 1'b1;
          wb_wreg  = 1'b0;
          wb_wdata = 32'd0;
        end else if (is_load) begin
          wb_wdata = load_res;
        end else if (is_store) begin
          wb_wreg  = 1'b0;
          wb_wdata = 32'd0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset is synchronous, so the state may still be ACCESS while rst is high;
    // quiet the bus and the stall request for that cycle.
    if (rst) begin
      stallreq_mem = 1'b0;
      ram_addr     = 32'd0;
      ram_wdata    = 8'd0;
      ram_we       = 1'b0;
      ram_re       = 1'b0;
      mem_err      = 1'b0;
      wb_wreg      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      buf_q   <= 32'd0;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage with a byte-memory model.
// Latency: checks N+2 occupancy and per-byte wait handling.
// Backpressure: the bench acts as the bus slave and inserts ram_ready wait cycles.
module tb_mem_stage;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [6:0]  mem_opcode;
  logic [2:0]  mem_func3;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq_mem;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [7:0]  ram_rdata;
  logic        ram_ready;
  logic        mem_err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] mem_m [logic [31:0]];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_opcode   (mem_opcode),
    .mem_func3    (mem_func3),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .stallreq_mem (stallreq_mem),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_re       (ram_re),
    .ram_rdata    (ram_rdata),
    .ram_ready    (ram_ready),
    .mem_err      (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return 8'h00;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // Architectural load value from the byte memory.
  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    byte         sb;
    shortint     sh;
    int          v;
    w = 0;
    for (int i = 0; i < nbytes(f3); i++) w = w + (32'(rd(a + 32'(i))) << (8 * i));
    case (f3)
      3'd0:    begin sb = w[7:0];  v = sb; return v; end
      3'd1:    begin sh = w[15:0]; v = sh; return v; end
      3'd4:    return w % 256;
      3'd5:    return w % 65536;
      default: return w;
    endcase
  endfunction

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] r2, input logic [4:0] wd, input logic wr,
                        input logic [31:0] wdat);
    mem_opcode = op; mem_func3 = f3; mem_mem_addr = a; mem_reg2 = r2;
    mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
  endtask

  // Drives one instruction (called just after a rising edge) and checks it to completion.
  task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] r2, input logic [4:0] wd,
                        input logic wr, input logic [31:0] wdat, input int dly);
    int          n, nx, stalls, waitc, cyc;
    bit          is_ld, is_st, done, both, bad_wreg;
    logic [31:0] xa [4];
    logic [7:0]  xd [4];
    logic        xw [4];
    logic [31:0] exp_res, d_wdata;
    logic [4:0]  d_wd;
    logic        d_wreg, d_err, d_strobe;
    n = nbytes(f3);
    is_ld = (op == OP_LD) && (n > 0);
    is_st = (op == OP_ST) && (n > 0);
    exp_res = is_ld ? load_val(f3, a) : 32'd0;
    nx = 0; stalls = 0; waitc = 0; cyc = 0; done = 0; both = 0; bad_wreg = 0;
    d_wdata = 0; d_wd = 0; d_wreg = 0; d_err = 0; d_strobe = 0;
    #1;
    set_in(op, f3, a, r2, wd, wr, wdat);
    if (!is_ld && !is_st) begin
      #1;
      chk({tag, "/pass_wdata"}, wb_wdata, wdat);
      chk({tag, "/pass_wreg"}, 32'(wb_wreg), 32'(wr));
      chk({tag, "/pass_wd"}, 32'(wb_wd), 32'(wd));
      chk({tag, "/pass_stall"}, 32'(stallreq_mem), 0);
      chk({tag, "/pass_strobe"}, 32'(ram_re | ram_we), 0);
      @(posedge clk);
      return;
    end
    while (!done && cyc < 80) begin
      #1;
      if (ram_re && ram_we) both = 1;
      if (stallreq_mem) begin
        stalls++;
        if (wb_wreg) bad_wreg = 1;
        if (ram_re || ram_we) begin
          if (waitc < dly) begin
            ram_ready = 0; ram_rdata = 8'($urandom); waitc++;
          end else begin
            if (nx < 4) begin xa[nx] = ram_addr; xw[nx] = ram_we; xd[nx] = ram_wdata; end
            nx++;
            ram_ready = 1; ram_rdata = rd(ram_addr); waitc = 0;
          end
        end else begin
          ram_ready = 0; ram_rdata = 8'($urandom);
        end
        @(posedge clk);
        cyc++;
      end else begin
        done = 1;
        d_wdata = wb_wdata; d_wreg = wb_wreg; d_wd = wb_wd; d_err = mem_err;
        d_strobe = ram_re | ram_we;
        ram_ready = 0;
      end
    end
    chk({tag, "/done"}, 32'(done), 1);
    chk({tag, "/stall_cycles"}, stalls, 1 + n * (dly + 1));
    chk({tag, "/xfers"}, nx, n);
    chk({tag, "/re_we_both"}, 32'(both), 0);
    chk({tag, "/wreg_in_stall"}, 32'(bad_wreg), 0);
    for (int i = 0; i < n && i < nx; i++) begin
      chk($sformatf("%s/addr%0d", tag, i), xa[i], a + 32'(i));
      chk($sformatf("%s/we%0d", tag, i), 32'(xw[i]), 32'(is_st));
      if (is_st) chk($sformatf("%s/wbyte%0d", tag, i), 32'(xd[i]), (r2 >> (8 * i)) & 32'hFF);
    end
    chk({tag, "/done_strobe"}, 32'(d_strobe), 0);
    chk({tag, "/done_err"}, 32'(d_err), 0);
    chk({tag, "/wb_wreg"}, 32'(d_wreg), is_ld ? 32'(wr) : 0);
    chk({tag, "/wb_wdata"}, d_wdata, exp_res);
    if (is_ld) chk({tag, "/wb_wd"}, 32'(d_wd), 32'(wd));
    if (is_st) for (int i = 0; i < n; i++) mem_m[a + 32'(i)] = 8'((r2 >> (8 * i)) & 32'hFF);
    @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          sel, dly, acc;
    bit          done;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [2:0]  ldf [5];
    ldf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    // Reset with a store presented: every bus/stall output must stay quiet.
    rst = 1; ram_ready = 1; ram_rdata = 0;
    set_in(OP_ST, 3'd2, 32'h40, 32'hDEADBEEF, 5'd3, 1'b1, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst/stall", 32'(stallreq_mem), 0);
    chk("rst/re", 32'(ram_re), 0);
    chk("rst/we", 32'(ram_we), 0);
    chk("rst/err", 32'(mem_err), 0);
    chk("rst/addr", ram_addr, 0);
    chk("rst/wdata", 32'(ram_wdata), 0);
    chk("rst/wb_wreg", 32'(wb_wreg), 0);
    set_in(OP_ALU, 3'd0, 0, 0, 5'd0, 1'b0, 0);
    rst = 0; ram_ready = 0;
    @(posedge clk);

    run_op("alu", OP_ALU, 3'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h12345678, 0);

    mem_m[32'h100] = 8'h78; mem_m[32'h101] = 8'h56;
    mem_m[32'h102] = 8'h34; mem_m[32'h103] = 8'h12;
    run_op("lw", OP_LD, 3'd2, 32'h100, 0, 5'd7, 1'b1, 32'h0, 0);

    mem_m[32'h8] = 8'h80;
    run_op("lb", OP_LD, 3'd0, 32'h8, 0, 5'd9, 1'b1, 32'h0, 0);
    run_op("lbu", OP_LD, 3'd4, 32'h8, 0, 5'd9, 1'b1, 32'h0, 0);
    run_op("lbu_again", OP_LD, 3'd4, 32'h8, 0, 5'd9, 1'b1, 32'h0, 0);

    run_op("sh_wrap", OP_ST, 3'd1, 32'hFFFFFFFF, 32'hAABBCCDD, 5'd1, 1'b1, 32'h0, 0);
    run_op("lhu_wrap", OP_LD, 3'd5, 32'hFFFFFFFF, 0, 5'd2, 1'b1, 32'h0, 1);

    run_op("lw_wait3", OP_LD, 3'd2, 32'h100, 0, 5'd11, 1'b1, 32'h0, 3);

    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 9);
      dly = $urandom_range(0, 2);
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
      if (sel <= 3) begin
        f3 = ldf[$urandom_range(0, 4)];
        for (int i = 0; i < 4; i++) if (!mem_m.exists(a + 32'(i))) mem_m[a + 32'(i)] = 8'($urandom);
        run_op($sformatf("rnd%0d_ld", k), OP_LD, f3, a, $urandom, 5'($urandom), 1'($urandom), $urandom, dly);
      end else if (sel <= 6) begin
        f3 = 3'($urandom_range(0, 2));
        run_op($sformatf("rnd%0d_st", k), OP_ST, f3, a, $urandom, 5'($urandom), 1'($urandom), $urandom, dly);
      end else if (sel <= 8) begin
        run_op($sformatf("rnd%0d_alu", k), OP_ALU, 3'($urandom), a, $urandom, 5'($urandom), 1'($urandom), $urandom, dly);
      end else begin
        f3 = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd7;
        run_op($sformatf("rnd%0d_badf3", k), OP_LD, f3, a, $urandom, 5'($urandom), 1'($urandom), $urandom, dly);
      end
    end

    // Bus never answers.
    #1;
    set_in(OP_LD, 3'd2, 32'h40, 0, 5'd4, 1'b1, 32'h0);
    ram_ready = 0;
    #1;
    chk("hang/idle_stall", 32'(stallreq_mem), 1);
    chk("hang/idle_re", 32'(ram_re), 0);
    @(posedge clk);
`ifdef MEM_BUS_TIMEOUT_EN
    acc = 0; done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      if (!stallreq_mem) begin
        done = 1;
        chk("to/err", 32'(mem_err), 1);
        chk("to/wb_wreg", 32'(wb_wreg), 0);
        chk("to/wb_wdata", wb_wdata, 0);
        chk("to/re", 32'(ram_re), 0);
      end else begin
        if (ram_re) acc++;
        @(posedge clk);
      end
    end
    chk("to/done", 32'(done), 1);
    chk("to/access_cycles", acc, 255);
    @(posedge clk);
    #1;
    chk("to/restart_err", 32'(mem_err), 0);
    @(posedge clk);
    #1;
`else
    repeat (300) @(posedge clk);
    #1;
    chk("hang/err", 32'(mem_err), 0);
    chk("hang/stall", 32'(stallreq_mem), 1);
`endif
    chk("hang/re", 32'(ram_re), 1);
    chk("hang/addr", ram_addr, 32'h40);

    // Reset in the middle of ACCESS.
    rst = 1;
    #1;
    chk("rst_mid/re_during", 32'(ram_re), 0);
    chk("rst_mid/stall_during", 32'(stallreq_mem), 0);
    @(posedge clk);
    #1;
    rst = 0;
    chk("rst_mid/re_next", 32'(ram_re), 0);
    set_in(OP_ALU, 3'd0, 0, 0, 5'd0, 1'b0, 0);
    @(posedge clk);

    run_op("lw_after_rst", OP_LD, 3'd2, 32'h100, 0, 5'd6, 1'b1, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
